// File: rtl/wrr_pkt_sched.sv
// Weighted round-robin packet scheduler: multiplexes NumIn valid/ready sources onto one stream,
// granting whole packets and allowing each source up to max(wgt,1) packets per turn.
module wrr_pkt_sched #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned WgtWidth  = 4,
  parameter int unsigned IdxWidth  = $clog2(NumIn)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [NumIn-1:0]               req_i,
  input  logic [NumIn-1:0]               last_i,
  input  logic [NumIn*DataWidth-1:0]     data_i,
  input  logic [NumIn*WgtWidth-1:0]      wgt_i,
  output logic [NumIn-1:0]               gnt_o,
  output logic                           req_o,
  output logic                           last_o,
  output logic [DataWidth-1:0]           data_o,
  output logic [IdxWidth-1:0]            idx_o,
  input  logic                           gnt_i,
  output logic                           busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    PKT
  } state_e;

  state_e               state_q, state_d;
  logic [IdxWidth-1:0]  cur_q, cur_d;
  logic [IdxWidth-1:0]  ptr_q, ptr_d;
  logic [WgtWidth-1:0]  cnt_q, cnt_d;

  logic [IdxWidth-1:0]  start, cand, pos;
  logic [IdxWidth:0]    sum;
  logic                 found;
  logic [WgtWidth-1:0]  wgt_sel, eff, left;
  logic                 new_turn, acc;

  // Circular search from start; a locked packet pins the candidate to its owner.
  always_comb begin
    start = (state_q == IDLE) ? ptr_q : cur_q;
    cand  = start;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    if (state_q != PKT) begin
      for (int unsigned k = 0; k < NumIn; k++) begin
        sum = {1'b0, start} + (IdxWidth+1)'(k);
        if (sum >= (IdxWidth+1)'(NumIn)) sum = sum - (IdxWidth+1)'(NumIn);
        pos = sum[IdxWidth-1:0];
        if (!found && req_i[pos]) begin
          cand  = pos;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_o   = rst_ni & req_i[cand];
    last_o  = last_i[cand];
    data_o  = data_i[int'(cand)*DataWidth +: DataWidth];
    idx_o   = cand;
    wgt_sel = wgt_i[int'(cand)*WgtWidth +: WgtWidth];
    gnt_o   = '0;
    if (rst_ni) gnt_o[cand] = gnt_i;
  end

  assign acc      = req_o & gnt_i;
  assign new_turn = (state_q == IDLE) || (state_q == TURN && cand != cur_q);
  assign eff      = new_turn ? ((wgt_sel == '0) ? WgtWidth'(1) : wgt_sel) : cnt_q;
  assign left     = eff - WgtWidth'(1);
  assign busy_o   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (acc && last_o) begin
      cur_d = cand;
      if (left == '0) begin
        state_d = IDLE;
        ptr_d   = (cand == IdxWidth'(NumIn - 1)) ? '0 : cand + 1'b1;
      end else begin
        cnt_d   = left;
        state_d = TURN;
      end
    end else if (acc && state_q != PKT) begin
      cur_d   = cand;
      cnt_d   = eff;
      state_d = PKT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_gnt_needs_ready : assert property (@(posedge clk_i) disable iff (!rst_ni) (|gnt_o) |-> gnt_i);
  a_pkt_idx_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == PKT && !flush_i && !(acc && last_o)) |=> (idx_o == $past(idx_o)));

endmodule

// File: tb/tb_wrr_pkt_sched.sv
// Bench for wrr_pkt_sched: directed scenarios followed by randomized traffic, all checked
// against a turn/credit reference model.
module tb_wrr_pkt_sched;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] data;
  logic [N*WW-1:0] wgt;
  logic [N-1:0]    gnt_o;
  logic            req_o;
  logic            last_o;
  logic [DW-1:0]   data_o;
  logic [IW-1:0]   idx_o;
  logic            gnt_i;
  logic            busy_o;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: a turn is active or not, optionally locked inside a packet, with an
  // owner, a count of packets still allowed, and the next search start used between turns.
  bit m_active;
  bit m_inpkt;
  int m_owner;
  int m_credit;
  int m_ptr;

  int obs_idx;
  bit obs_busy;
  bit obs_req;
  logic [N-1:0] obs_gnt;

  wrr_pkt_sched #(
    .NumIn    (N),
    .DataWidth(DW),
    .WgtWidth (WW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .req_i  (req),
    .last_i (last),
    .data_i (data),
    .wgt_i  (wgt),
    .gnt_o  (gnt_o),
    .req_o  (req_o),
    .last_o (last_o),
    .data_o (data_o),
    .idx_o  (idx_o),
    .gnt_i  (gnt_i),
    .busy_o (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0;
    m_inpkt  = 0;
    m_owner  = 0;
    m_credit = 0;
    m_ptr    = 0;
  endfunction

  function automatic int wgt_of(input int i);
    int w;
    w = int'(wgt[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int model_cand();
    int start;
    if (m_inpkt) return m_owner;
    start = m_active ? m_owner : m_ptr;
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return start;
  endfunction

  // One clock: inputs are already applied after a falling edge; check, clock, update model.
  task automatic step();
    int c;
    bit er;
    bit fresh;
    int base;
    c  = 0;
    er = 0;
    #1;
    obs_idx  = int'(idx_o);
    obs_busy = busy_o;
    obs_req  = req_o;
    obs_gnt  = gnt_o;
    if (!rst_n) begin
      chk("rst_req_o", req_o, 0);
      chk("rst_gnt_o", gnt_o, 0);
    end else begin
      c  = model_cand();
      er = req[c];
      chk("busy_o", busy_o, m_active);
      chk("req_o", req_o, er);
      if (er || m_inpkt) begin
        chk("idx_o", idx_o, c);
        chk("gnt_o", gnt_o, gnt_i ? (64'd1 << c) : 64'd0);
      end
      if (er) begin
        chk("data_o", data_o, data[c*DW +: DW]);
        chk("last_o", last_o, last[c]);
      end
    end
    @(posedge clk);
    if (!rst_n || flush) begin
      model_reset();
    end else if (er && gnt_i) begin
      fresh = !m_active || (!m_inpkt && c != m_owner);
      base  = fresh ? wgt_of(c) : m_credit;
      if (last[c]) begin
        m_owner = c;
        m_inpkt = 0;
        if (base - 1 == 0) begin
          m_active = 0;
          m_ptr    = (c + 1) % N;
        end else begin
          m_active = 1;
          m_credit = base - 1;
        end
      end else if (!m_inpkt) begin
        m_owner  = c;
        m_inpkt  = 1;
        m_active = 1;
        m_credit = base;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) data[i*DW +: DW] = $urandom;
  endtask

  int seq1[6];
  int seq2[9];

  initial begin
    seq1 = '{0, 1, 2, 3, 0, 1};
    seq2 = '{0, 0, 1, 2, 2, 2, 3, 0, 0};
    model_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    req   = 4'hF;
    last  = 4'hF;
    wgt   = 16'h1111;
    gnt_i = 1'b1;
    rand_data();
    @(negedge clk);

    // Reset holds the output side quiet even with every source requesting.
    step();
    step();
    rst_n = 1'b1;

    // Unit weights, single-beat packets: plain rotation.
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step();
      chk("t1_idx", obs_idx, seq1[i]);
    end

    // Weighted turns.
    do_flush();
    wgt = 16'h0312;
    for (int i = 0; i < 9; i++) begin
      rand_data();
      step();
      chk("t2_idx", obs_idx, seq2[i]);
    end

    // Multi-beat packet from src1 with a downstream stall; src0 stays locked out.
    do_flush();
    wgt   = 16'h1111;
    req   = 4'b0010;
    last  = 4'b0000;
    step();
    chk("t3_idx_b1", obs_idx, 1);
    req   = 4'b0011;
    gnt_i = 1'b0;
    step();
    chk("t3_idx_stall", obs_idx, 1);
    chk("t3_gnt_stall", obs_gnt, 0);
    gnt_i = 1'b1;
    step();
    chk("t3_idx_b2", obs_idx, 1);
    chk("t3_gnt0_b2", obs_gnt[0], 0);
    last = 4'b0010;
    step();
    chk("t3_idx_b3", obs_idx, 1);
    chk("t3_gnt0_b3", obs_gnt[0], 0);
    step();
    chk("t3_next_src0", obs_idx, 0);

    // Owner drops out mid-turn: next requester is served without a bubble.
    do_flush();
    wgt  = 16'h0203;
    req  = 4'b0101;
    last = 4'hF;
    step();
    chk("t4_idx_src0", obs_idx, 0);
    req = 4'b0100;
    step();
    chk("t4_idx_src2", obs_idx, 2);
    chk("t4_req_o", obs_req, 1);
    step();
    chk("t4_idx_src2_again", obs_idx, 2);

    // Flush aborts a packet from src3.
    do_flush();
    req  = 4'b1000;
    last = 4'b0000;
    step();
    chk("t5_idx_src3", obs_idx, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    req   = 4'b1001;
    step();
    chk("t5_busy", obs_busy, 0);
    chk("t5_idx", obs_idx, 0);

    // Largest weight from a lone source: 15 packets, then a new turn.
    do_flush();
    wgt  = 16'h00F0;
    req  = 4'b0010;
    last = 4'hF;
    for (int i = 0; i < 15; i++) step();
    step();
    chk("t6_busy", obs_busy, 0);
    chk("t6_idx", obs_idx, 1);
    step();
    chk("t6_busy_again", obs_busy, 1);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 63) == 0);
      req   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      last  = 4'($urandom);
      gnt_i = ($urandom_range(0, 3) != 0);
      if (cyc % 40 == 0) wgt = 16'($urandom);
      rand_data();
      step();
    end
    rst_n = 1'b1;
    flush = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
